// File: rtl/tx_ram_wr_ctrl.sv
// TX word capture and BRAM port-B frame-ring writer for the V/N coder mux.
// Optional TX_WR_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module tx_ram_wr_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned LAST_CNT    = 31,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned FRAME_WORDS = 16
) (
  input  logic              clk_15_o,
  input  logic              nrst,
  input  logic [CNT_W-1:0]  cnt_data,
  input  logic [DATA_W-1:0] data_in_ram_tx_reg_b,
  input  logic              mvsk_on,
  input  logic              mnsk_on,
  input  logic              rd_ack,
  input  logic              ovf_clr,
  output logic              bram_en_b,
  output logic              bram_we_b,
  output logic [ADDR_W-1:0] bram_addr_b,
  output logic [DATA_W-1:0] bram_din_b,
  output logic              frame_rdy,
  output logic [ADDR_W-1:0] frame_base,
  output logic [ADDR_W:0]   frames_pending,
  output logic              overflow
`ifdef TX_WR_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam int unsigned NUM_FRAMES = DEPTH / FRAME_WORDS;
  localparam int unsigned FW_B       = $clog2(FRAME_WORDS);
  localparam int unsigned FR_B       = ADDR_W - FW_B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_prev_q;
  logic [DATA_W-1:0]   cap_word_q, cap_word_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FR_B-1:0]     rd_frame_q, rd_frame_d;
  logic [ADDR_W:0]     pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic [FW_B-1:0]     drop_cnt_q, drop_cnt_d;

  logic                mode_on;
  logic                word_done;
  logic                space;
  logic                at_boundary;
  logic                frame_done;
  logic                ack_ok;
  logic                capture;
  logic                ovf_set;
  logic [ADDR_W-1:0]   ptr_after;

  assign mode_on     = mvsk_on | mnsk_on;
  assign word_done   = (cnt_prev_q == CNT_W'(LAST_CNT)) && (cnt_data == '0) && mode_on;
  assign space       = pend_q < (ADDR_W + 1)'(NUM_FRAMES);
  assign at_boundary = (wr_ptr_q[FW_B-1:0] == '0);
  assign frame_done  = wr_pend_q && (wr_ptr_q[FW_B-1:0] == '1);
  assign ack_ok      = rd_ack && (pend_q != '0);
  assign ptr_after   = wr_pend_q ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;

  always_comb begin
    state_d    = state_q;
    cap_word_d = cap_word_q;
    wr_pend_d  = 1'b0;
    wr_ptr_d   = ptr_after;
    drop_cnt_d = drop_cnt_q;
    ovf_set    = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        drop_cnt_d = '0;
        if (mode_on) state_d = space ? S_RUN : S_DROP;
      end
      S_RUN: begin
        if (!mode_on) begin
          // Any in-flight write lands first, then the partial frame is discarded.
          state_d  = S_IDLE;
          wr_ptr_d = {ptr_after[ADDR_W-1:FW_B], {FW_B{1'b0}}};
        end else if (word_done) begin
          if (at_boundary && !space) begin
            state_d    = S_DROP;
            drop_cnt_d = FW_B'(1);
            ovf_set    = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!mode_on) begin
          state_d    = S_IDLE;
          drop_cnt_d = '0;
        end else if (word_done) begin
          // A fresh drop count sits on a frame boundary: accept the frame if room appeared.
          if (drop_cnt_q == '0 && space) begin
            capture = 1'b1;
            state_d = S_RUN;
          end else begin
            if (drop_cnt_q == '0) ovf_set = 1'b1;
            if (drop_cnt_q == '1) begin
              drop_cnt_d = '0;
              state_d    = space ? S_RUN : S_DROP;
            end else begin
              drop_cnt_d = drop_cnt_q + FW_B'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      cap_word_d = data_in_ram_tx_reg_b;
      wr_pend_d  = 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q;
    unique case ({frame_done, ack_ok})
      2'b10:   pend_d = pend_q + (ADDR_W + 1)'(1);
      2'b01:   pend_d = pend_q - (ADDR_W + 1)'(1);
      default: pend_d = pend_q;
    endcase
    rd_frame_d = ack_ok ? (rd_frame_q + FR_B'(1)) : rd_frame_q;
    ovf_d      = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_prev_q <= '0;
      cap_word_q <= '0;
      wr_pend_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_frame_q <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_prev_q <= cnt_data;
      cap_word_q <= cap_word_d;
      wr_pend_q  <= wr_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_frame_q <= rd_frame_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef TX_WR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign bram_en_b      = wr_pend_q;
  assign bram_we_b      = wr_pend_q;
  assign bram_addr_b    = wr_ptr_q;
  assign bram_din_b     = cap_word_q;
  assign frame_rdy      = (pend_q != '0);
  assign frame_base     = {rd_frame_q, {FW_B{1'b0}}};
  assign frames_pending = pend_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_tx_ram_wr_ctrl.sv
// Scoreboard bench for tx_ram_wr_ctrl: expected BRAM writes are queued by the
// stimulus and checked by a negedge monitor; status outputs are checked inline.
module tb_tx_ram_wr_ctrl;

  logic        clk;
  logic        nrst;
  logic [4:0]  cnt_data;
  logic [31:0] data_in;
  logic        mvsk_on, mnsk_on, rd_ack, ovf_clr;
  logic        bram_en_b, bram_we_b;
  logic [5:0]  bram_addr_b;
  logic [31:0] bram_din_b;
  logic        frame_rdy;
  logic [5:0]  frame_base;
  logic [6:0]  frames_pending;
  logic        overflow;
`ifdef TX_WR_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  tx_ram_wr_ctrl #(
    .DATA_W(32), .CNT_W(5), .LAST_CNT(31), .ADDR_W(6), .FRAME_WORDS(16)
  ) dut (
    .clk_15_o             (clk),
    .nrst                 (nrst),
    .cnt_data             (cnt_data),
    .data_in_ram_tx_reg_b (data_in),
    .mvsk_on              (mvsk_on),
    .mnsk_on              (mnsk_on),
    .rd_ack               (rd_ack),
    .ovf_clr              (ovf_clr),
    .bram_en_b            (bram_en_b),
    .bram_we_b            (bram_we_b),
    .bram_addr_b          (bram_addr_b),
    .bram_din_b           (bram_din_b),
    .frame_rdy            (frame_rdy),
    .frame_base           (frame_base),
    .frames_pending       (frames_pending),
    .overflow             (overflow)
`ifdef TX_WR_FRAME_CNT_EN
    ,
    .frame_cnt            (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int unsigned c;
  } exp_t;

  exp_t sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (nrst && bram_we_b) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                 bram_addr_b, bram_din_b, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr",  64'(bram_addr_b), 64'(e.a));
        chk("wr_data",  64'(bram_din_b),  64'(e.d));
        chk("wr_cycle", 64'(cyc),         64'(e.c));
        chk("wr_en",    64'(bram_en_b),   64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One word: counter at LAST_CNT, then 0 (word_done), then the strobe cycle.
  task automatic send_word(input logic [31:0] d, input bit exp_wr, input logic [5:0] a,
                           input bit ack, input bit off);
    cnt_data = 5'd31;
    data_in  = d;
    @(posedge clk); #1;
    cnt_data = 5'd0;
    if (exp_wr) sb.push_back('{a, d, cyc + 1});
    @(posedge clk); #1;
    cnt_data = 5'd1;
    data_in  = ~d;
    if (ack) rd_ack = 1'b1;
    if (off) begin
      mvsk_on = 1'b0;
      mnsk_on = 1'b0;
    end
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base_d, input bit exp_wr, input logic [5:0] a0);
    for (int i = 0; i < 16; i++) send_word(base_d + 32'(i), exp_wr, a0 + 6'(i), 1'b0, 1'b0);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   64'(bram_en_b),      64'd0);
    chk({tag, "_we"},   64'(bram_we_b),      64'd0);
    chk({tag, "_addr"}, 64'(bram_addr_b),    64'd0);
    chk({tag, "_din"},  64'(bram_din_b),     64'd0);
    chk({tag, "_rdy"},  64'(frame_rdy),      64'd0);
    chk({tag, "_base"}, 64'(frame_base),     64'd0);
    chk({tag, "_pend"}, 64'(frames_pending), 64'd0);
    chk({tag, "_ovf"},  64'(overflow),       64'd0);
  endtask

  initial begin
    nrst = 1'b0; cnt_data = '0; data_in = '0;
    mvsk_on = 1'b0; mnsk_on = 1'b0; rd_ack = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    nrst = 1'b1;
    @(posedge clk); #1;

    // First frame in VSK mode at addresses 0..15
    mvsk_on = 1'b1;
    @(posedge clk); #1;
    send_frame(32'h1000_0000, 1'b1, 6'd0);
    @(posedge clk); #1;
    chk("f0_pend", 64'(frames_pending), 64'd1);
    chk("f0_rdy",  64'(frame_rdy),      64'd1);
    chk("f0_base", 64'(frame_base),     64'd0);

    // Fill the ring, then one frame must be dropped
    send_frame(32'h2000_0010, 1'b1, 6'd16);
    send_frame(32'h2000_0020, 1'b1, 6'd32);
    send_frame(32'h2000_0030, 1'b1, 6'd48);
    chk("full_pend", 64'(frames_pending), 64'd4);
    chk("full_ovf",  64'(overflow),       64'd0);
    send_frame(32'h3000_0000, 1'b0, 6'd0);
    chk("drop_ovf",  64'(overflow),       64'd1);
    chk("drop_pend", 64'(frames_pending), 64'd4);

    pulse_ack();
    chk("ack1_pend", 64'(frames_pending), 64'd3);
    chk("ack1_base", 64'(frame_base),     64'd16);
    send_frame(32'h4000_0000, 1'b1, 6'd0);
    chk("f6_pend", 64'(frames_pending), 64'd4);
    chk("f6_ovf",  64'(overflow),       64'd1);
`ifdef TX_WR_FRAME_CNT_EN
    chk("f6_fcnt", 64'(frame_cnt), 64'd5);
`endif
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovfclr", 64'(overflow), 64'd0);

    // Drain; an extra rd_ack with nothing pending is ignored
    repeat (4) pulse_ack();
    chk("drain_pend", 64'(frames_pending), 64'd0);
    chk("drain_rdy",  64'(frame_rdy),      64'd0);
    chk("drain_base", 64'(frame_base),     64'd16);
    pulse_ack();
    chk("ign_pend", 64'(frames_pending), 64'd0);
    chk("ign_base", 64'(frame_base),     64'd16);

    // Mode drop after 5 words; the 5th write completes during the drop
    for (int i = 0; i < 4; i++) send_word(32'h5000_0000 + 32'(i), 1'b1, 6'd16 + 6'(i), 1'b0, 1'b0);
    send_word(32'h5000_0004, 1'b1, 6'd20, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("mdrop_pend", 64'(frames_pending), 64'd0);
    mnsk_on = 1'b1;
    @(posedge clk); #1;
    send_frame(32'h6000_0000, 1'b1, 6'd16);
    chk("renab_pend", 64'(frames_pending), 64'd1);
    chk("renab_base", 64'(frame_base),     64'd16);

    // rd_ack coincident with a frame completion
    for (int i = 0; i < 15; i++) send_word(32'h7000_0000 + 32'(i), 1'b1, 6'd32 + 6'(i), 1'b0, 1'b0);
    send_word(32'h7000_000F, 1'b1, 6'd47, 1'b1, 1'b0);
    chk("coinc_pend", 64'(frames_pending), 64'd1);
    chk("coinc_base", 64'(frame_base),     64'd32);
`ifdef TX_WR_FRAME_CNT_EN
    chk("coinc_fcnt", 64'(frame_cnt), 64'd7);
`endif

    // Asynchronous reset while the write strobe is high
    cnt_data = 5'd31;
    data_in  = 32'h8000_0000;
    @(posedge clk); #1;
    cnt_data = 5'd0;
    @(posedge clk); #1;
    chk("rstw_we",   64'(bram_we_b),   64'd1);
    chk("rstw_addr", 64'(bram_addr_b), 64'd48);
    #1;
    nrst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cnt_data = 5'd1;
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(32'h9000_0000, 1'b1, 6'd0);
    chk("post_pend", 64'(frames_pending), 64'd1);
    chk("post_base", 64'(frame_base),     64'd0);
`ifdef TX_WR_FRAME_CNT_EN
    chk("post_fcnt", 64'(frame_cnt), 64'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
